id_stage: RTL and testbench

Parametrised, registered RV32I/RV64I decode stage with an integrated ID/EX pipeline register. It decodes OP-IMM, OP, LUI and AUIPC instructions, reads the register file, and selects operands with EX/MEM forwarding. It detects load-use hazards and inserts bubbles. It sits between the IF/ID register and the execute stage, and exchanges valid/ready handshakes on both sides.

---
 rtl/id_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Registered RV32I/RV64I decode stage: decodes OP-IMM/OP/LUI/AUIPC, selects forwarded
// operands, stalls on load-use hazards and holds the result in the ID/EX register.
module id_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [31:0]           inst_i,
    output logic                  reg1_read_o,
    output logic                  reg2_read_o,
    output logic [REG_ADDR_W-1:0] reg1_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]       reg1_data_i,
    input  logic [XLEN-1:0]       reg2_data_i,
    input  logic                  ex_wreg_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic [XLEN-1:0]       ex_wdata_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic [XLEN-1:0]       mem_wdata_i,
    input  logic                  flush_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6:0]            aluop_o,
    output logic [2:0]            alufunct3_o,
    output logic                  alufunct7b5_o,
    output logic [XLEN-1:0]       reg1_o,
    output logic [XLEN-1:0]       reg2_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    function automatic logic [XLEN-1:0] pick_operand(
        input logic            nz,
        input logic            ex_hit,
        input logic            mem_hit,
        input logic [XLEN-1:0] ex_data,
        input logic [XLEN-1:0] mem_data,
        input logic [XLEN-1:0] rf_data
    );
        if (!nz)               return '0;
        if (FWD_EN && ex_hit)  return ex_data;
        if (FWD_EN && mem_hit) return mem_data;
        return rf_data;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic signed [11:0] imm12;
    logic signed [31:0] immu32;
    logic [XLEN-1:0] imm_i, imm_u;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign funct7      = inst_i[31:25];
    assign imm12       = inst_i[31:20];
    assign immu32      = {inst_i[31:12], 12'b0};
    assign imm_i       = XLEN'(imm12);
    assign imm_u       = XLEN'(immu32);
    assign reg1_addr_o = inst_i[15 +: REG_ADDR_W];
    assign reg2_addr_o = inst_i[20 +: REG_ADDR_W];

    logic nz1, nz2, ex_any1, ex_any2, mem_any1, mem_any2;
    logic haz1, haz2, hazard, load;
    logic [XLEN-1:0] fwd1, fwd2;

    assign nz1      = reg1_addr_o != '0;
    assign nz2      = reg2_addr_o != '0;
    assign ex_any1  = ex_wreg_i && (ex_wd_i == reg1_addr_o);
    assign ex_any2  = ex_wreg_i && (ex_wd_i == reg2_addr_o);
    assign mem_any1 = mem_wreg_i && (mem_wd_i == reg1_addr_o);
    assign mem_any2 = mem_wreg_i && (mem_wd_i == reg2_addr_o);

    // Without forwarding, any in-flight producer of a source register must be waited out.
    assign haz1 = reg1_read_o && nz1 &&
                  ((ex_any1 && ex_is_load_i) || (!FWD_EN && (ex_any1 || mem_any1)));
    assign haz2 = reg2_read_o && nz2 &&
                  ((ex_any2 && ex_is_load_i) || (!FWD_EN && (ex_any2 || mem_any2)));
    assign hazard = haz1 || haz2;

    assign fwd1 = pick_operand(nz1, ex_any1 && !ex_is_load_i, mem_any1,
                               ex_wdata_i, mem_wdata_i, reg1_data_i);
    assign fwd2 = pick_operand(nz2, ex_any2 && !ex_is_load_i, mem_any2,
                               ex_wdata_i, mem_wdata_i, reg2_data_i);

    logic            illegal_d, wreg_d;
    logic [XLEN-1:0] reg1_d, reg2_d;

    always_comb begin
        reg1_read_o = 1'b0;
        reg2_read_o = 1'b0;
        illegal_d   = 1'b1;
        reg1_d      = '0;
        reg2_d      = '0;
        unique case (opcode)
            OPC_OPIMM: begin
                reg1_read_o = 1'b1;
                reg1_d      = fwd1;
                reg2_d      = imm_i;
                illegal_d   = 1'b0;
                if (funct3 == 3'b001)
                    illegal_d = (inst_i[31:26] != 6'b0) || ((XLEN == 32) && inst_i[25]);
                else if (funct3 == 3'b101)
                    illegal_d = ((inst_i[31:26] != 6'b000000) && (inst_i[31:26] != 6'b010000)) ||
                                ((XLEN == 32) && inst_i[25]);
            end
            OPC_OP: begin
                reg1_read_o = 1'b1;
                reg2_read_o = 1'b1;
                reg1_d      = fwd1;
                reg2_d      = fwd2;
                illegal_d   = !((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_LUI: begin
                reg2_d    = imm_u;
                illegal_d = 1'b0;
            end
            OPC_AUIPC: begin
                reg1_d    = pc_i;
                reg2_d    = imm_u;
                illegal_d = 1'b0;
            end
            default: ;
        endcase
        if (illegal_d) begin
            reg1_d = '0;
            reg2_d = '0;
        end
        wreg_d = !illegal_d;
    end

    logic                  out_valid_q, wreg_q, illegal_q, funct7b5_q;
    logic [6:0]            aluop_q;
    logic [2:0]            funct3_q;
    logic [XLEN-1:0]       reg1_q, reg2_q;
    logic [REG_ADDR_W-1:0] wd_q;

    assign in_ready = flush_i || ((!out_valid_q || out_ready) && !hazard);
    assign load     = in_valid && in_ready && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            wreg_q      <= 1'b0;
            illegal_q   <= 1'b0;
            aluop_q     <= OPC_OPIMM;
            funct3_q    <= 3'b0;
            funct7b5_q  <= 1'b0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wd_q        <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            wreg_q      <= wreg_d;
            illegal_q   <= illegal_d;
            aluop_q     <= opcode;
            funct3_q    <= funct3;
            funct7b5_q  <= inst_i[30];
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wd_q        <= inst_i[7 +: REG_ADDR_W];
        end else if (out_ready) begin
            // Consumed with nothing new accepted (idle or hazard bubble).
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign wreg_o        = wreg_q;
    assign illegal_o     = illegal_q;
    assign aluop_o       = aluop_q;
    assign alufunct3_o   = funct3_q;
    assign alufunct7b5_o = funct7b5_q;
    assign reg1_o        = reg1_q;
    assign reg2_o        = reg2_q;
    assign wd_o          = wd_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage (XLEN=32, forwarding on): directed vector table, hand-built
// hazard/stall/flush/reset sequences, then random traffic against a reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] pc_i, inst_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i;
    logic        out_valid, out_ready;
    logic [6:0]  aluop_o;
    logic [2:0]  alufunct3_o;
    logic        alufunct7b5_o;
    logic [31:0] reg1_o, reg2_o;
    logic [4:0]  wd_o;
    logic        wreg_o, illegal_o;

    id_stage #(.XLEN(32), .REG_ADDR_W(5), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i),
        .ex_wdata_i(ex_wdata_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
        .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop_o(aluop_o), .alufunct3_o(alufunct3_o), .alufunct7b5_o(alufunct7b5_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".wreg"}, 32'(wreg_o), 32'd0);
        chk({tag, ".illegal"}, 32'(illegal_o), 32'd0);
        chk({tag, ".aluop"}, 32'(aluop_o), 32'h13);
        chk({tag, ".f3"}, 32'(alufunct3_o), 32'd0);
        chk({tag, ".f7b5"}, 32'(alufunct7b5_o), 32'd0);
        chk({tag, ".reg1"}, reg1_o, 32'd0);
        chk({tag, ".reg2"}, reg2_o, 32'd0);
        chk({tag, ".wd"}, 32'(wd_o), 32'd0);
    endtask

    typedef struct {
        logic [31:0] inst, pc, rf1, rf2;
        logic        exw;
        logic [4:0]  exd;
        logic [31:0] exdat;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic        wreg, ill;
        logic [2:0]  f3;
        logic        b5;
    } vec_t;

    typedef struct {
        logic        rd1, rd2, haz, ill, wreg;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic [6:0]  op;
        logic [2:0]  f3;
    } model_t;

    // Decode straight from the ISA rules on 32-bit words.
    function automatic model_t model(
        input logic [31:0] inst, pc, rf1, rf2,
        input logic exw, exl, input logic [4:0] exd, input logic [31:0] exdat,
        input logic mw, input logic [4:0] md, input logic [31:0] mdat);
        model_t m;
        logic [4:0] rs [2];
        logic [31:0] rf [2];
        logic [31:0] val [2];
        logic [31:0] immi, immu;
        logic [6:0] f7;
        rs[0] = inst[19:15]; rs[1] = inst[24:20];
        rf[0] = rf1; rf[1] = rf2;
        immi = $signed(inst) >>> 20;
        immu = inst & 32'hFFFF_F000;
        f7   = inst[31:25];
        m.op = inst[6:0]; m.f3 = inst[14:12]; m.wd = inst[11:7];
        m.rd1 = 0; m.rd2 = 0; m.ill = 0; m.haz = 0; m.r1 = 0; m.r2 = 0;
        for (int p = 0; p < 2; p++) begin
            if (rs[p] == 0) val[p] = 0;
            else if (exw && exd == rs[p] && !exl) val[p] = exdat;
            else if (mw && md == rs[p]) val[p] = mdat;
            else val[p] = rf[p];
        end
        case (m.op)
            7'h13: begin
                m.rd1 = 1; m.r1 = val[0]; m.r2 = immi;
                if (m.f3 == 1) m.ill = f7 != 0;
                else if (m.f3 == 5) m.ill = !(f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                m.rd1 = 1; m.rd2 = 1; m.r1 = val[0]; m.r2 = val[1];
                m.ill = !(f7 == 0 || (f7 == 7'h20 && (m.f3 == 0 || m.f3 == 5)));
            end
            7'h37: m.r2 = immu;
            7'h17: begin m.r1 = pc; m.r2 = immu; end
            default: m.ill = 1;
        endcase
        if (m.ill) begin m.r1 = 0; m.r2 = 0; end
        m.wreg = !m.ill;
        m.haz = (m.rd1 && rs[0] != 0 && exl && exw && exd == rs[0]) ||
                (m.rd2 && rs[1] != 0 && exl && exw && exd == rs[1]);
        return m;
    endfunction

    vec_t vec [13];
    model_t m, expq;
    logic   ev, exp_ready;
    logic [31:0] w;
    int k;

    initial begin
        vec[0]  = '{32'hFFB10093, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'hFFFFFFFB, 1, 1, 0, 0, 1};
        vec[1]  = '{32'h123452B7, 0, 32'h77, 32'h88, 0, 0, 0, 0, 0, 0, 0, 32'h12345000, 5, 1, 0, 5, 0};
        vec[2]  = '{32'h12345297, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h12345000, 5, 1, 0, 5, 0};
        vec[3]  = '{32'h002081B3, 0, 32'h11, 32'h22, 1, 1, 32'hAAAA, 1, 1, 32'hBBBB, 32'hAAAA, 32'h22, 3, 1, 0, 0, 0};
        vec[4]  = '{32'h002081B3, 0, 32'h11, 32'h22, 1, 1, 32'hAAAA, 1, 2, 32'hBBBB, 32'hAAAA, 32'hBBBB, 3, 1, 0, 0, 0};
        vec[5]  = '{32'h002001B3, 0, 32'h55, 32'h22, 1, 0, 32'hDEAD, 0, 0, 0, 0, 32'h22, 3, 1, 0, 0, 0};
        vec[6]  = '{32'hFFFFFFFF, 0, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 1, 7, 1};
        vec[7]  = '{32'h02111093, 0, 32'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
        vec[8]  = '{32'h40315093, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0, 32'h80, 32'h403, 1, 1, 0, 5, 1};
        vec[9]  = '{32'h402081B3, 0, 32'h7, 32'h2, 0, 0, 0, 0, 0, 0, 32'h7, 32'h2, 3, 1, 0, 0, 1};
        vec[10] = '{32'h402091B3, 0, 32'h7, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1};
        vec[11] = '{32'h002081B3, 0, 32'h11, 32'h22, 0, 2, 32'h9999, 1, 2, 32'hCCCC, 32'h11, 32'hCCCC, 3, 1, 0, 0, 0};
        vec[12] = '{32'hFFF0F213, 0, 32'h3, 0, 0, 0, 0, 1, 1, 32'h1234, 32'h1234, 32'hFFFFFFFF, 4, 1, 0, 7, 1};

        rst = 0; in_valid = 0; out_ready = 1; flush_i = 0; pc_i = 0; inst_i = 32'h13;
        reg1_data_i = 0; reg2_data_i = 0; ex_wreg_i = 0; ex_is_load_i = 0; ex_wd_i = 0;
        ex_wdata_i = 0; mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
        tick(); tick();
        chk_reset("rst");
        rst = 1;
        tick();

        foreach (vec[i]) begin
            inst_i = vec[i].inst; pc_i = vec[i].pc;
            reg1_data_i = vec[i].rf1; reg2_data_i = vec[i].rf2;
            ex_wreg_i = vec[i].exw; ex_is_load_i = 0; ex_wd_i = vec[i].exd; ex_wdata_i = vec[i].exdat;
            mem_wreg_i = vec[i].mw; mem_wd_i = vec[i].md; mem_wdata_i = vec[i].mdat;
            in_valid = 1; out_ready = 1;
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("v%0d.addr1", i), 32'(reg1_addr_o), 32'(vec[i].inst[19:15]));
            chk($sformatf("v%0d.addr2", i), 32'(reg2_addr_o), 32'(vec[i].inst[24:20]));
            tick();
            chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d.reg1", i), reg1_o, vec[i].r1);
            chk($sformatf("v%0d.reg2", i), reg2_o, vec[i].r2);
            chk($sformatf("v%0d.wreg", i), 32'(wreg_o), 32'(vec[i].wreg));
            chk($sformatf("v%0d.illegal", i), 32'(illegal_o), 32'(vec[i].ill));
            chk($sformatf("v%0d.f3", i), 32'(alufunct3_o), 32'(vec[i].f3));
            chk($sformatf("v%0d.f7b5", i), 32'(alufunct7b5_o), 32'(vec[i].b5));
            chk($sformatf("v%0d.aluop", i), 32'(aluop_o), 32'(vec[i].inst[6:0]));
            if (!vec[i].ill) chk($sformatf("v%0d.wd", i), 32'(wd_o), 32'(vec[i].wd));
        end

        // Load-use: ADDI x1,x2,1 behind a load into x2.
        inst_i = 32'h00110093; pc_i = 0; reg1_data_i = 32'h30; reg2_data_i = 0;
        ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 2; mem_wreg_i = 0;
        in_valid = 1; out_ready = 1;
        #1;
        chk("lu.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("lu.bubble", 32'(out_valid), 32'd0);
        ex_wreg_i = 0; ex_is_load_i = 0;
        #1;
        chk("lu.in_ready2", 32'(in_ready), 32'd1);
        tick();
        chk("lu.valid", 32'(out_valid), 32'd1);
        chk("lu.reg1", reg1_o, 32'h30);
        chk("lu.reg2", reg2_o, 32'h1);

        // Downstream stall for three cycles with a new instruction pending.
        out_ready = 0; inst_i = 32'h123452B7;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d.in_ready", c), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("st%0d.valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("st%0d.reg1", c), reg1_o, 32'h30);
            chk($sformatf("st%0d.reg2", c), reg2_o, 32'h1);
            chk($sformatf("st%0d.wd", c), 32'(wd_o), 32'd1);
        end
        flush_i = 1;
        #1;
        chk("fl.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.reg2_kept", reg2_o, 32'h1);
        flush_i = 0; in_valid = 0; out_ready = 1;
        tick();
        chk("fl.dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        in_valid = 1; inst_i = 32'h123452B7;
        tick();
        chk("ar.valid", 32'(out_valid), 32'd1);
        in_valid = 0;
        #2 rst = 0;
        #1 chk_reset("ar");
        tick();
        rst = 1;
        tick();

        // Random traffic against the model.
        ev = 0; expq = '{default: 0};
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            k = $urandom_range(0, 5);
            case (k)
                0, 5: begin
                    w[6:0] = 7'h13; w[19:15] = 5'($urandom_range(0, 3));
                    if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                        case ($urandom_range(0, 2))
                            0: w[31:26] = 6'h00;
                            1: w[31:26] = 6'h10;
                            default: ;
                        endcase
                        w[25] = ($urandom_range(0, 3) == 0);
                    end
                end
                1: begin
                    w[6:0] = 7'h33; w[19:15] = 5'($urandom_range(0, 3)); w[24:20] = 5'($urandom_range(0, 3));
                    case ($urandom_range(0, 2))
                        0: w[31:25] = 7'h00;
                        1: w[31:25] = 7'h20;
                        default: ;
                    endcase
                end
                2: w[6:0] = 7'h37;
                3: w[6:0] = 7'h17;
                default: ;
            endcase
            inst_i = w; pc_i = $urandom; reg1_data_i = $urandom; reg2_data_i = $urandom;
            ex_wreg_i = $urandom_range(0, 1); ex_is_load_i = ($urandom_range(0, 2) == 0);
            ex_wd_i = 5'($urandom_range(0, 3)); ex_wdata_i = $urandom;
            mem_wreg_i = $urandom_range(0, 1); mem_wd_i = 5'($urandom_range(0, 3)); mem_wdata_i = $urandom;
            in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            m = model(inst_i, pc_i, reg1_data_i, reg2_data_i, ex_wreg_i, ex_is_load_i, ex_wd_i,
                      ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
            exp_ready = flush_i || ((!ev || out_ready) && !m.haz);
            #1;
            chk($sformatf("r%0d.in_ready", n), 32'(in_ready), 32'(exp_ready));
            chk($sformatf("r%0d.rd1", n), 32'(reg1_read_o), 32'(m.rd1));
            chk($sformatf("r%0d.rd2", n), 32'(reg2_read_o), 32'(m.rd2));
            if (flush_i) ev = 0;
            else if (in_valid && exp_ready) begin ev = 1; expq = m; end
            else if (out_ready) ev = 0;
            tick();
            chk($sformatf("r%0d.valid", n), 32'(out_valid), 32'(ev));
            if (ev) begin
                chk($sformatf("r%0d.reg1", n), reg1_o, expq.r1);
                chk($sformatf("r%0d.reg2", n), reg2_o, expq.r2);
                chk($sformatf("r%0d.wreg", n), 32'(wreg_o), 32'(expq.wreg));
                chk($sformatf("r%0d.illegal", n), 32'(illegal_o), 32'(expq.ill));
                chk($sformatf("r%0d.aluop", n), 32'(aluop_o), 32'(expq.op));
                chk($sformatf("r%0d.f3", n), 32'(alufunct3_o), 32'(expq.f3));
                chk($sformatf("r%0d.wd", n), 32'(wd_o), 32'(expq.wd));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
